// File: rtl/alu_share_arbiter_if.sv
// Requester-side bus of the shared ALU arbiter: two request channels and one
// shared response channel, each with valid/ready handshakes.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 24
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2:0]       req_op0;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [2:0]       req_op1;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic             resp_err;

  modport master (
    output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between the execute datapath
// (requester 0) and the branch-compare/address unit (requester 1).
module alu_share_arbiter #(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_arbiter_if.slave   bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_sel,
  output logic                 alu_binvert,
  output logic                 alu_cin,
  input  logic [WIDTH-1:0]     alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Decoded control word: {illegal, sel[2:0], binvert, cin}.
  function automatic logic [5:0] decode_op(input logic [2:0] op);
    case (op)
      3'b000:  decode_op = {1'b0, 3'b000, 1'b0, 1'b0};
      3'b001:  decode_op = {1'b0, 3'b001, 1'b0, 1'b0};
      3'b010:  decode_op = {1'b0, 3'b010, 1'b0, 1'b0};
      3'b011:  decode_op = {1'b0, 3'b011, 1'b1, 1'b1};
      3'b110:  decode_op = {1'b0, 3'b010, 1'b1, 1'b1};
      3'b111:  decode_op = {1'b0, 3'b011, 1'b1, 1'b1};
      default: decode_op = {1'b1, 3'b000, 1'b0, 1'b0};
    endcase
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             ptr_r;
  logic             grant_r;
  logic             err_r;
  logic             winner_s;
  logic             accept_s;
  logic             resp_done_s;
  logic [1:0]       req_ready_s;
  logic [2:0]       op_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [5:0]       dec_s;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [2:0]       alu_sel_r;
  logic             alu_binvert_r;
  logic             alu_cin_r;
  logic [1:0]       resp_valid_r;
  logic [WIDTH-1:0] resp_result_r;
  logic             resp_zero_r;
  logic             resp_err_r;

  assign accept_s    = (state_r == IDLE) && (bus.req_valid != 2'b00);
  assign resp_done_s = (state_r == RESP) && bus.resp_ready[grant_r];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req_valid != 2'b00) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (bus.resp_ready[grant_r]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Arbitration and request-side outputs: a lone requester wins outright,
  // a tie goes to the pointer.
  always_comb begin
    winner_s    = ptr_r;
    req_ready_s = 2'b00;
    if (bus.req_valid == 2'b11) begin
      winner_s = ptr_r;
    end else begin
      winner_s = bus.req_valid[1];
    end
    if (accept_s) begin
      req_ready_s = winner_s ? 2'b10 : 2'b01;
    end else begin
      req_ready_s = 2'b00;
    end
    op_s  = winner_s ? bus.req_op1 : bus.req_op0;
    a_s   = winner_s ? bus.req_a1  : bus.req_a0;
    b_s   = winner_s ? bus.req_b1  : bus.req_b0;
    dec_s = decode_op(op_s);
  end

  // Datapath: ALU drive registers live only for the EXEC cycle, response
  // registers only for RESP; everything else sits at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r         <= 1'b0;
      grant_r       <= 1'b0;
      err_r         <= 1'b0;
      alu_a_r       <= {WIDTH{1'b0}};
      alu_b_r       <= {WIDTH{1'b0}};
      alu_sel_r     <= 3'b000;
      alu_binvert_r <= 1'b0;
      alu_cin_r     <= 1'b0;
      resp_valid_r  <= 2'b00;
      resp_result_r <= {WIDTH{1'b0}};
      resp_zero_r   <= 1'b0;
      resp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            grant_r       <= winner_s;
            err_r         <= dec_s[5];
            alu_sel_r     <= dec_s[4:2];
            alu_binvert_r <= dec_s[1];
            alu_cin_r     <= dec_s[0];
            // Illegal opcodes leave the ALU idle.
            alu_a_r       <= dec_s[5] ? {WIDTH{1'b0}} : a_s;
            alu_b_r       <= dec_s[5] ? {WIDTH{1'b0}} : b_s;
          end
        end
        EXEC: begin
          resp_valid_r  <= grant_r ? 2'b10 : 2'b01;
          resp_result_r <= err_r ? {WIDTH{1'b0}} : alu_result;
          resp_zero_r   <= err_r ? 1'b1 : (alu_result == {WIDTH{1'b0}});
          resp_err_r    <= err_r;
          alu_a_r       <= {WIDTH{1'b0}};
          alu_b_r       <= {WIDTH{1'b0}};
          alu_sel_r     <= 3'b000;
          alu_binvert_r <= 1'b0;
          alu_cin_r     <= 1'b0;
        end
        RESP: begin
          if (resp_done_s) begin
            ptr_r         <= ~grant_r;
            resp_valid_r  <= 2'b00;
            resp_result_r <= {WIDTH{1'b0}};
            resp_zero_r   <= 1'b0;
            resp_err_r    <= 1'b0;
          end
        end
        default: begin
          resp_valid_r <= 2'b00;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_s;
  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_result = resp_result_r;
  assign bus.resp_zero   = resp_zero_r;
  assign bus.resp_err    = resp_err_r;
  assign alu_a           = alu_a_r;
  assign alu_b           = alu_b_r;
  assign alu_sel         = alu_sel_r;
  assign alu_binvert     = alu_binvert_r;
  assign alu_cin         = alu_cin_r;

endmodule
